// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - MIPS32 5-stage pipeline interlock, mult/div sequencing and memory-wait watchdog
module pipe_stall_ctrl #(
    parameter int unsigned MD_CYCLES       = 32,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter bit          FLUSH_ON_BRANCH = 1'b0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        lu_hazard,
    input  logic        md_start,
    input  logic        md_use,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        wpc,
    output logic        wpcir,
    output logic        bubble,
    output logic        freeze_back,
    output logic        flush_if,
    output logic        md_busy,
    output logic        md_done,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    localparam int MDW = $clog2(MD_CYCLES + 1);
    localparam int WW  = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {ST_RUN, ST_MEMW} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MDW-1:0]   r_md_cnt;
    logic [WW-1:0]    r_wait_cnt;
    logic             r_md_done;
    logic             r_mem_err;
    logic [31:0]      r_stall_cycles;
    logic             w_freeze;
    logic             w_id_stall;
    logic             w_md_accept;

    assign w_freeze    = mem_req & ~mem_ack;
    assign md_busy     = (r_md_cnt != '0);
    assign w_id_stall  = lu_hazard | (md_busy & (md_use | md_start));
    assign w_md_accept = md_start & ~md_busy & ~w_freeze & ~lu_hazard;

    assign md_done      = r_md_done;
    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;

    // Memory wait freezes the back end wholesale; ID hazards only inject a bubble.
    always_comb begin
        wpc         = 1'b1;
        wpcir       = 1'b1;
        bubble      = 1'b0;
        freeze_back = 1'b0;
        if (!resetn) begin
            wpc    = 1'b0;
            wpcir  = 1'b0;
            bubble = 1'b1;
        end else if (w_freeze) begin
            wpc         = 1'b0;
            wpcir       = 1'b0;
            freeze_back = 1'b1;
        end else if (w_id_stall) begin
            wpc    = 1'b0;
            wpcir  = 1'b0;
            bubble = 1'b1;
        end
        flush_if = FLUSH_ON_BRANCH & branch_taken & wpcir;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_freeze) w_state_nxt = ST_MEMW;
            ST_MEMW: if (!w_freeze) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_md_cnt       <= '0;
            r_md_done      <= 1'b0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (!w_freeze)
                r_wait_cnt <= '0;
            else if (r_state == ST_RUN)
                r_wait_cnt <= WW'(1);
            else if (r_wait_cnt != '1)
                r_wait_cnt <= r_wait_cnt + WW'(1);

            if (w_freeze && (r_wait_cnt == WW'(MEM_TIMEOUT)))
                r_mem_err <= 1'b1;

            // The iterative unit keeps counting through freezes.
            if (w_md_accept)
                r_md_cnt <= MDW'(MD_CYCLES);
            else if (md_busy)
                r_md_cnt <= r_md_cnt - MDW'(1);

            r_md_done <= (r_md_cnt == MDW'(1));

            if (!wpc)
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule
